// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin sharing of one registered ALU among NREQ requesters, with IDLE/RUN/DRAIN quiesce.
// Optional ALU_SCHED_PERF_EN adds saturating issue/conflict counters.
module alu_rr_scheduler #(
  parameter int N    = 16,
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [2:0]        alu_op,
  input  logic [N-1:0]      alu_result,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_data,
  output logic              busy
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_issue_cnt,
  output logic [31:0]       perf_conflict_cnt
`endif
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, win, iss_id, res_id;
  logic found, accept, iss_vld, res_vld, empty;
  // Scan from farthest to nearest so the requester closest after ptr is left as the winner.
  always_comb begin
    win = ptr;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        win = IW'((int'(ptr) + k) % NREQ);
        found = 1'b1;
      end
    end
  end
  assign empty  = !iss_vld && !res_vld;
  assign accept = state == RUN && en && found;
  always_comb begin
    state_nx = state;
    if (en) state_nx = RUN;
    else if (state == IDLE || empty) state_nx = IDLE;
    else state_nx = DRAIN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= IW'(NREQ - 1);
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= 3'd7;
      iss_vld <= 1'b0;
      res_vld <= 1'b0;
      iss_id  <= '0;
      res_id  <= '0;
    end else begin
      state   <= state_nx;
      iss_vld <= accept;
      res_vld <= iss_vld;
      res_id  <= iss_id;
      if (accept) begin
        alu_a  <= req_a[int'(win)*N +: N];
        alu_b  <= req_b[int'(win)*N +: N];
        alu_op <= req_op[int'(win)*3 +: 3];
        iss_id <= win;
        ptr    <= win;
      end
    end
  end
  assign req_ready = accept ? NREQ'(1) << win : '0;
  assign rsp_valid = res_vld ? NREQ'(1) << res_id : '0;
  assign rsp_data  = alu_result;
  assign busy      = state != IDLE;
`ifdef ALU_SCHED_PERF_EN
  logic conflict;
  assign conflict = state == RUN && en && $countones(req_valid) >= 2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else if (state == IDLE && state_nx == RUN) begin
      perf_issue_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (accept && !(&perf_issue_cnt)) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (conflict && !(&perf_conflict_cnt)) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif
endmodule
